// File: rtl/inst_encoder.sv
// RV32 instruction encoder: field bundle in, 32-bit word out through a
// 2-deep FIFO; illegal opcodes or out-of-range immediates are counted and dropped.
module inst_encoder (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [6:0]  opcode_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] imm_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] inst_o,
   output logic        err_o,
   output logic [7:0]  err_cnt_o
);

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_B  = 7'b1100011;

   logic [1:0][31:0] mem_q, mem_d;
   logic [1:0]       count_q, count_d;
   logic             wptr_q, wptr_d;
   logic             rptr_q, rptr_d;
   logic             err_q, err_d;
   logic [7:0]       err_cnt_q, err_cnt_d;

   logic [31:0] enc;
   logic        legal;
   logic        imm_ok;
   logic        accept;
   logic        push;
   logic        pop;

   // Immediate must fit a signed 12-bit field (B: half-offset).
   assign imm_ok = (&imm_i[31:11]) | ~(|imm_i[31:11]);

   always_comb begin
      enc   = '0;
      legal = 1'b0;
      unique case (opcode_i)
         OP_R: begin
            enc   = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            legal = 1'b1;
         end
         OP_I, OP_LW: begin
            enc   = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            legal = imm_ok;
         end
         OP_SW: begin
            enc   = {imm_i[11:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:0], opcode_i};
            legal = imm_ok;
         end
         OP_B: begin
            enc   = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i,
                     imm_i[3:0], imm_i[10], opcode_i};
            legal = imm_ok;
         end
         default: ;
      endcase
   end

   assign ready_o   = count_q < 2'd2;
   assign valid_o   = count_q != 2'd0;
   assign inst_o    = valid_o ? mem_q[rptr_q] : '0;
   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;

   assign accept = valid_i & ready_o;
   assign push   = accept & legal;
   assign pop    = valid_o & ready_i;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
         mem_d[wptr_q] = enc;
         wptr_d        = ~wptr_q;
      end
      if (pop) begin
         rptr_d = ~rptr_q;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: ;
      endcase
   end

   always_comb begin
      err_d     = accept & ~legal;
      err_cnt_d = err_cnt_q;
      if (err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mem_q     <= '0;
         count_q   <= '0;
         wptr_q    <= 1'b0;
         rptr_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         mem_q     <= mem_d;
         count_q   <= count_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: Inst_Encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk_i  input  1  clock, all state on rising edge.
REQ-003 rst_i  input  1  asynchronous active-low reset.
REQ-004 valid_i  input  1  request valid.
REQ-005 ready_o  output  1  block can accept a request.
REQ-006 opcode_i  input  7  0110011 R, 0010011 I, 0000011 LW, 0100011 SW, 1100011 B.
REQ-007 rd_i, rs1_i, rs2_i  input  5 each  register indices.
REQ-008 funct3_i  input  3; funct7_i  input  7  function fields.
REQ-009 imm_i  input  32  signed immediate, same value domain the immediate generator produces (B: half-offset, unshifted).
REQ-010 valid_o  output  1  encoded word valid.
REQ-011 ready_i  input  1  consumer accepts word.
REQ-012 inst_o  output  32  encoded instruction word.
REQ-013 err_o  output  1  one-cycle pulse for a rejected request.
REQ-014 err_cnt_o  output  8  count of rejected requests, saturating.

Function
REQ-015 Accept SHALL occur on a rising edge with valid_i=1 and ready_o=1; other cycles SHALL leave all inputs ignored.
REQ-016 Encoding: R = {funct7, rs2, rs1, funct3, rd, opcode}; imm_i ignored.
REQ-017 Encoding: I and LW = {imm[11:0], rs1, funct3, rd, opcode}.
REQ-018 Encoding: SW = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-019 Encoding: B = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode}.
REQ-020 Round-trip: the immediate generator applied to any word from I/LW/SW/B SHALL return imm_i exactly.
REQ-021 Range check: for I/LW/SW/B, imm_i[31:11] SHALL be all-equal; otherwise reject.
REQ-022 Any opcode not in REQ-006 SHALL be rejected.
REQ-023 Rejected requests SHALL be consumed (handshake completes), SHALL NOT enter the buffer, SHALL pulse err_o the cycle after accept, and SHALL increment err_cnt_o, holding at 255.
REQ-024 Valid encodings SHALL be written to a 2-entry FIFO on accept; inst_o/valid_o SHALL present the head entry, registered.
REQ-025 Latency: word accepted into an empty FIFO SHALL appear with valid_o=1 on the next cycle.
REQ-026 Pop SHALL occur on a rising edge with valid_o=1 and ready_i=1; output order SHALL equal accept order.
REQ-027 ready_o SHALL be 1 iff occupancy < 2 (pure function of registered occupancy, no ready_i combinational path).
REQ-028 Simultaneous push and pop at occupancy 1 SHALL keep occupancy 1 with the new word at head next cycle.
REQ-029 Full (occupancy 2): ready_o=0; a pop that cycle frees space only from the next cycle.
REQ-030 valid_o=0 SHALL hold when empty; inst_o is then 0.
REQ-031 inst_o and valid_o SHALL remain stable while valid_o=1 and ready_i=0.
REQ-032 Read/write pointers SHALL wrap modulo 2; occupancy SHALL be 2-bit, 0..2 only.

Reset
REQ-033 rst_i=0 SHALL immediately (asynchronously) force valid_o=0, inst_o=0, err_o=0, err_cnt_o=0, occupancy=0, pointers=0, ready_o=1.
REQ-034 Reset mid-operation SHALL discard buffered words and any pending err_o pulse; first post-reset accept behaves as from empty.

Verification
REQ-035 addi: opcode 0010011, rd=1, rs1=0, funct3=0, imm=-1, ready_i=1 -> next cycle valid_o=1, inst_o=0xFFF00093.
REQ-036 sw: opcode 0100011, rs2=2, rs1=3, funct3=010, imm=8 -> inst_o=0x0021A423; beq: opcode 1100011, rs1=1, rs2=2, funct3=0, imm=4 -> inst_o=0x00208463.
REQ-037 I-type imm=2048, then imm=-2049 -> err_o pulses twice, no valid_o, err_cnt_o=2; 300 rejects -> err_cnt_o=255.
REQ-038 ready_i=0, three back-to-back valid requests A,B,C -> ready_o=0 after B, C held; ready_i=1 -> outputs A,B,C in order, no loss or duplicate.
REQ-039 Occupancy 2 then rst_i=0 mid-cycle -> valid_o=0, ready_o=1 without a clock edge; post-release request appears alone after 1 cycle.
REQ-040 Random round-trip: 10k legal requests decoded by the immediate generator -> immediate equals imm_i, register/funct fields match.
